// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its execute-stage controller: widths,
// opcode encodings and the controller state encoding.
package alu_pkg;

    localparam int ALU_W    = 16;
    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 5'b00000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 5'b00001;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 5'b01000;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 5'b01010;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 5'b01100;

    typedef enum logic [1:0] {
        EXEC_IDLE = 2'd0,
        EXEC_EXEC = 2'd1,
        EXEC_DONE = 2'd2
    } exec_state_e;

endpackage

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: registers one op onto the alu inputs, captures the alu
// result/flags a cycle later and hands them downstream. Option macro: ALU_ACC_FWD_EN.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int W    = ALU_W,
    parameter int OP_W = ALU_OP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  logic [W-1:0]    in_a,
    input  logic [W-1:0]    in_b,
`ifdef ALU_ACC_FWD_EN
    input  logic            in_use_acc,
`endif
    output logic [OP_W-1:0] alu_op,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_result,
    input  logic [3:0]      alu_flags,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_result,
    output logic [3:0]      out_flags
);

    exec_state_e     state_q, state_d;
    logic [OP_W-1:0] alu_op_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [W-1:0]    out_result_q;
    logic [3:0]      out_flags_q;
    logic            accept;
    logic [W-1:0]    a_src;

`ifdef ALU_ACC_FWD_EN
    // The accumulator is captured on the same edge and reset as out_result, so share it.
    logic [W-1:0] acc;
    assign acc   = out_result_q;
    assign a_src = in_use_acc ? acc : in_a;
`else
    assign a_src = in_a;
`endif

    assign in_ready = (state_q == EXEC_IDLE) || ((state_q == EXEC_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC_IDLE: if (accept) state_d = EXEC_EXEC;
            EXEC_EXEC: state_d = EXEC_DONE;
            EXEC_DONE: begin
                // Retiring with a new op waiting goes straight back to EXEC, no bubble.
                if (out_ready) state_d = in_valid ? EXEC_EXEC : EXEC_IDLE;
            end
            default:   state_d = EXEC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EXEC_IDLE;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_op_q <= in_op;
                alu_a_q  <= a_src;
                alu_b_q  <= in_b;
            end
            if (state_q == EXEC_EXEC) begin
                out_result_q <= alu_result;
                out_flags_q  <= alu_flags;
            end
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign out_valid  = (state_q == EXEC_DONE);
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural alu sibling.
// Alu flags here are {negative, zero, result[0], odd parity}.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_use_acc;
    logic [4:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.W(16), .OP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
`ifdef ALU_ACC_FWD_EN
        .in_use_acc (in_use_acc),
`endif
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    // Behavioural alu: XOR for ALU_OP_XOR, addition for everything else.
    always_comb begin
        alu_result = (alu_op == ALU_OP_XOR) ? (alu_a ^ alu_b) : (alu_a + alu_b);
        alu_flags  = {alu_result[15], (alu_result == 16'h0), alu_result[0], ^alu_result};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        in_use_acc = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_alu_op", {11'd0, alu_op}, 16'd0);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_out_flags", {12'd0, out_flags}, 16'd0);
        rst = 1'b0;
        tick();

        // 1: -32 XOR 5 = -27, out_ready held high
        out_ready = 1'b1;
        issue(ALU_OP_XOR, 16'hFFE0, 16'h0005);
        #1 chk("t1_in_ready", {15'd0, in_ready}, 16'd1);
        tick(); in_valid = 1'b0; #1;
        chk("t1_exec_valid", {15'd0, out_valid}, 16'd0);
        chk("t1_exec_ready", {15'd0, in_ready}, 16'd0);
        chk("t1_alu_a", alu_a, 16'hFFE0);
        chk("t1_alu_b", alu_b, 16'h0005);
        chk("t1_alu_op", {11'd0, alu_op}, {11'd0, ALU_OP_XOR});
        tick();
        chk("t1_valid", {15'd0, out_valid}, 16'd1);
        chk("t1_result", out_result, 16'hFFE5);
        chk("t1_flags", {12'd0, out_flags}, 16'h000B);
        tick();
        chk("t1_retired", {15'd0, out_valid}, 16'd0);
        chk("t1_idle_ready", {15'd0, in_ready}, 16'd1);
        chk("t1_alu_a_hold", alu_a, 16'hFFE0);

        // 3: back-to-back, 100 XOR 1 retires while 16 XOR 16 is accepted
        out_ready = 1'b0;
        issue(ALU_OP_XOR, 16'd100, 16'd1);
        tick(); in_valid = 1'b0; tick();
        chk("t3_first_valid", {15'd0, out_valid}, 16'd1);
        chk("t3_first_result", out_result, 16'h0065);
        chk("t3_first_flags", {12'd0, out_flags}, 16'h0002);
        issue(ALU_OP_XOR, 16'd16, 16'd16);
        out_ready = 1'b1;
        #1 chk("t3_comb_ready", {15'd0, in_ready}, 16'd1);
        tick(); in_valid = 1'b0; #1;
        chk("t3_exec_valid", {15'd0, out_valid}, 16'd0);
        chk("t3_exec_ready", {15'd0, in_ready}, 16'd0);
        chk("t3_alu_a", alu_a, 16'h0010);
        tick();
        chk("t3_second_valid", {15'd0, out_valid}, 16'd1);
        chk("t3_second_result", out_result, 16'h0000);
        chk("t3_second_flags", {12'd0, out_flags}, 16'h0004);
        tick();
        chk("t3_no_dup", {15'd0, out_valid}, 16'd0);

        // 2: backpressure, -13 XOR -3 = 14 held for 5 cycles
        out_ready = 1'b0;
        issue(ALU_OP_XOR, 16'hFFF3, 16'hFFFD);
        tick(); in_valid = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("t2_hold_result", out_result, 16'h000E);
            chk("t2_hold_flags", {12'd0, out_flags}, 16'h0001);
            chk("t2_hold_ready", {15'd0, in_ready}, 16'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t2_retired", {15'd0, out_valid}, 16'd0);
        chk("t2_idle_ready", {15'd0, in_ready}, 16'd1);

        // Unknown opcode is forwarded; behavioural alu adds: 3 + 4 = 7
        issue(5'b11111, 16'd3, 16'd4);
        tick(); in_valid = 1'b0; #1;
        chk("unk_alu_op", {11'd0, alu_op}, 16'h001F);
        tick();
        chk("unk_result", out_result, 16'h0007);
        chk("unk_flags", {12'd0, out_flags}, 16'h0003);
        tick();

        // 4: reset while 9 XOR 0 is in EXEC
        issue(ALU_OP_XOR, 16'd9, 16'd0);
        tick(); in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("t4_valid", {15'd0, out_valid}, 16'd0);
        chk("t4_result", out_result, 16'h0000);
        chk("t4_flags", {12'd0, out_flags}, 16'd0);
        chk("t4_alu_a", alu_a, 16'h0000);
        chk("t4_alu_op", {11'd0, alu_op}, 16'd0);
        rst = 1'b0;
        #1 chk("t4_ready_after", {15'd0, in_ready}, 16'd1);
        tick();
        chk("t4_no_valid1", {15'd0, out_valid}, 16'd0);
        tick();
        chk("t4_no_valid2", {15'd0, out_valid}, 16'd0);
        chk("t4_ready_idle", {15'd0, in_ready}, 16'd1);

`ifdef ALU_ACC_FWD_EN
        // 5: 16 XOR -10 = -26, then acc XOR -26 = 0
        out_ready = 1'b1;
        issue(ALU_OP_XOR, 16'd16, 16'hFFF6);
        tick(); in_valid = 1'b0; tick();
        chk("t5_op1_result", out_result, 16'hFFE6);
        chk("t5_op1_flags", {12'd0, out_flags}, 16'h0009);
        tick();
        issue(ALU_OP_XOR, 16'd999, 16'hFFE6);
        in_use_acc = 1'b1;
        tick(); in_valid = 1'b0; in_use_acc = 1'b0; #1;
        chk("t5_alu_a_acc", alu_a, 16'hFFE6);
        chk("t5_alu_b", alu_b, 16'hFFE6);
        tick();
        chk("t5_op2_result", out_result, 16'h0000);
        chk("t5_op2_flags", {12'd0, out_flags}, 16'h0004);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
